// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_frame_ctrl
// Brief   : Frame sequencer for a K=3 rate-1/2 Viterbi ACS + survivor memory.
// Revision: 1.0  initial release
// ============================================================================
module viterbi_frame_ctrl #(
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] frame_len,
    input  logic [1:0]    sym_in,
    input  logic          sym_valid,
    output logic          sym_ready,
    output logic          acs_en,
    output logic          acs_init,
    output logic [AW-1:0] surv_waddr,
    input  logic [1:0]    best_state,
    output logic [AW-1:0] surv_raddr,
    input  logic [3:0]    surv_rdata,
    output logic          dec_bit,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACQ    = 3'd1,
        SETTLE = 3'd2,
        TB     = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam logic [AW-1:0] C_MIN_LEN = AW'(3);
    localparam logic [AW-1:0] C_MAX_LEN = AW'(DEPTH);
    localparam logic [AW-1:0] C_ONE     = AW'(1);

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_len;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_tb_idx;
    logic [AW-1:0]   r_out_idx;
    logic [1:0]      r_tb_state;
    logic [DEPTH-1:0] r_bits;
    logic            r_dec_valid;
    logic            r_dec_bit;
    logic            r_done;
    logic [AW-1:0]   w_last;
    logic [AW-1:0]   w_len_clamped;
    logic            w_accept;
    logic            w_out_accept;

    assign w_last        = r_len - C_ONE;
    assign w_len_clamped = (frame_len < C_MIN_LEN) ? C_MIN_LEN :
                           (frame_len > C_MAX_LEN) ? C_MAX_LEN : frame_len;

    // Reset masks the ready so a symbol presented during reset is never taken.
    assign sym_ready    = (r_state == ACQ) & ~rst;
    assign w_accept     = sym_valid & sym_ready;
    assign acs_en       = w_accept;
    assign acs_init     = w_accept & (r_idx == '0);
    assign surv_waddr   = (r_state == ACQ) ? r_idx : '0;
    assign surv_raddr   = (r_state == TB) ? r_tb_idx : '0;
    assign dec_valid    = r_dec_valid;
    assign dec_bit      = r_dec_bit;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign w_out_accept = r_dec_valid & dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = ACQ;
            ACQ:     if (w_accept && (r_idx == w_last)) w_state_next = SETTLE;
            SETTLE:  w_state_next = TB;
            TB:      if (r_tb_idx == '0) w_state_next = OUT;
            OUT:     if (w_out_accept && (r_out_idx == w_last)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_tb_idx    <= '0;
            r_out_idx   <= '0;
            r_tb_state  <= '0;
            r_bits      <= '0;
            r_dec_valid <= 1'b0;
            r_dec_bit   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len <= w_len_clamped;
                        r_idx <= '0;
                    end
                end
                ACQ: begin
                    // The index stops at N-1 so it never exceeds the memory range.
                    if (w_accept && (r_idx != w_last)) r_idx <= r_idx + C_ONE;
                end
                SETTLE: begin
                    r_tb_state <= best_state;
                    r_tb_idx   <= w_last;
                end
                TB: begin
                    r_bits[r_tb_idx] <= r_tb_state[1];
                    r_tb_state       <= {r_tb_state[0], surv_rdata[r_tb_state]};
                    if (r_tb_idx == '0) begin
                        r_out_idx <= '0;
                    end else begin
                        r_tb_idx <= r_tb_idx - C_ONE;
                    end
                end
                OUT: begin
                    // Output stage is registered: first cycle in OUT loads bit 0.
                    if (!r_dec_valid) begin
                        r_dec_valid <= 1'b1;
                        r_dec_bit   <= r_bits[r_out_idx];
                    end else if (dec_ready) begin
                        if (r_out_idx == w_last) begin
                            r_dec_valid <= 1'b0;
                            r_dec_bit   <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_out_idx <= r_out_idx + C_ONE;
                            r_dec_bit <= r_bits[r_out_idx + C_ONE];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
